// File: rtl/gru_seq_sequencer.sv
// gru_seq_sequencer: single-clock sequencing controller for a recurrent GRU
// datapath. It accepts one input vector per timestep, holds the inputs of an
// external fixed-latency gruCell stable while the cell computes, and feeds each
// step's hidden state back as the next step's previous state. The state is
// cleared at every sequence boundary. Hidden states are emitted over a
// valid/ready output: either the last step of each sequence only, or every step.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   x_t/x_valid/x_first input vector stream; x_first forces step 0
//   x_ready             sequencer can accept x_t (IDLE state)
//   cell_x, cell_h_prev registered, held-stable inputs to the external cell
//   cell_h              cell result, sampled CELL_LATENCY cycles after accept
//   h_out/h_valid/h_last/h_ready  hidden-state output stream
//   step_idx            timestep index of the current/last accepted step
module gru_seq_sequencer #(
  parameter int unsigned x_SIZE           = 6,
  parameter int unsigned h_SIZE           = 120,
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned SEQ_LEN          = 15,
  parameter int unsigned CELL_LATENCY     = 18,
  parameter int unsigned RETURN_SEQUENCES = 0
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [WIDTH*x_SIZE-1:0]                         x_t,
  input  logic                                            x_valid,
  input  logic                                            x_first,
  output logic                                            x_ready,
  output logic [WIDTH*x_SIZE-1:0]                         cell_x,
  output logic [WIDTH*h_SIZE-1:0]                         cell_h_prev,
  input  logic [WIDTH*h_SIZE-1:0]                         cell_h,
  output logic [WIDTH*h_SIZE-1:0]                         h_out,
  output logic                                            h_valid,
  output logic                                            h_last,
  input  logic                                            h_ready,
  output logic [((SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1)-1:0] step_idx
);

  localparam int unsigned XW = WIDTH * x_SIZE;
  localparam int unsigned HW = WIDTH * h_SIZE;
  localparam int unsigned SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int unsigned LW = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;
  localparam logic        RET_SEQ = (RETURN_SEQUENCES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  state_e          state_q;
  logic [SW-1:0]   step_idx_q;
  logic [LW-1:0]   lat_cnt_q;
  logic [HW-1:0]   h_state_q;
  logic [XW-1:0]   cell_x_q;
  logic [HW-1:0]   cell_h_prev_q;
  logic [HW-1:0]   h_out_q;
  logic            h_valid_q;
  logic            h_last_q;

  logic [SW-1:0]   step_eff;
  logic            step_is_last;
  logic            lat_done;

  // Step index an accept in IDLE will use: x_first restarts the sequence.
  always_comb begin
    step_eff = step_idx_q;
    if (x_first) begin
      step_eff = '0;
    end
  end

  assign step_is_last = (step_idx_q == SW'(SEQ_LEN - 1));
  assign lat_done     = (lat_cnt_q == LW'(CELL_LATENCY - 1));

  // Sequencer FSM with all datapath and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      step_idx_q    <= '0;
      lat_cnt_q     <= '0;
      h_state_q     <= '0;
      cell_x_q      <= '0;
      cell_h_prev_q <= '0;
      h_out_q       <= '0;
      h_valid_q     <= 1'b0;
      h_last_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (x_valid) begin
            cell_x_q      <= x_t;
            step_idx_q    <= step_eff;
            // Step 0 always starts from a zero state, so nothing leaks across
            // sequence boundaries or abandoned partial sequences.
            cell_h_prev_q <= (step_eff == '0) ? '0 : h_state_q;
            lat_cnt_q     <= '0;
            state_q       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (lat_done) begin
            h_state_q <= cell_h;
            if (RET_SEQ || step_is_last) begin
              h_out_q   <= cell_h;
              h_valid_q <= 1'b1;
              h_last_q  <= step_is_last;
              state_q   <= ST_EMIT;
            end else begin
              step_idx_q <= step_idx_q + SW'(1);
              state_q    <= ST_IDLE;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + LW'(1);
          end
        end
        ST_EMIT: begin
          if (h_ready) begin
            step_idx_q <= h_last_q ? '0 : (step_idx_q + SW'(1));
            h_valid_q  <= 1'b0;
            h_last_q   <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is a state decode; it is additionally held low while reset is
  // asserted so nothing appears acceptable during a multi-cycle reset.
  assign x_ready     = (state_q == ST_IDLE) && !reset;
  assign cell_x      = cell_x_q;
  assign cell_h_prev = cell_h_prev_q;
  assign h_out       = h_out_q;
  assign h_valid     = h_valid_q;
  assign h_last      = h_last_q;
  assign step_idx    = step_idx_q;

endmodule

// File: tb/tb_gru_seq_sequencer.sv
// Bench for gru_seq_sequencer: instance 0 emits the final step only, instance 1
// emits every step. Each drives a stub cell computing h[i] = h_prev[i] + x[0]
// with a pipeline that delivers the result by the capture edge.
module tb_gru_seq_sequencer;

  localparam int unsigned XS = 6;
  localparam int unsigned HS = 8;
  localparam int unsigned W  = 16;
  localparam int unsigned SL = 3;
  localparam int unsigned CL = 4;
  localparam int unsigned XB = W * XS;
  localparam int unsigned HB = W * HS;

  typedef struct {
    int          d;
    logic [W-1:0] x0;
    logic        first;
    logic [1:0]  step;
    logic [W-1:0] prev;
    logic        emit;
    logic [W-1:0] h;
    logic        last;
  } vec_t;

  logic          clk;
  logic          reset;
  logic [XB-1:0] x_t         [2];
  logic          x_valid     [2];
  logic          x_first     [2];
  logic          x_ready     [2];
  logic [XB-1:0] cell_x      [2];
  logic [HB-1:0] cell_h_prev [2];
  logic [HB-1:0] cell_h      [2];
  logic [HB-1:0] h_out       [2];
  logic          h_valid     [2];
  logic          h_last      [2];
  logic          h_ready     [2];
  logic [1:0]    step_idx    [2];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gru_seq_sequencer #(
      .x_SIZE(XS), .h_SIZE(HS), .WIDTH(W), .SEQ_LEN(SL),
      .CELL_LATENCY(CL), .RETURN_SEQUENCES(g)
    ) u_dut (
      .clk(clk), .reset(reset),
      .x_t(x_t[g]), .x_valid(x_valid[g]), .x_first(x_first[g]), .x_ready(x_ready[g]),
      .cell_x(cell_x[g]), .cell_h_prev(cell_h_prev[g]), .cell_h(cell_h[g]),
      .h_out(h_out[g]), .h_valid(h_valid[g]), .h_last(h_last[g]), .h_ready(h_ready[g]),
      .step_idx(step_idx[g])
    );

    // Stub cell: CL-1 register stages so the result is settled at the capture edge.
    logic [HB-1:0] stage [CL-1];
    always_ff @(posedge clk) begin
      for (int i = 0; i < HS; i++) begin
        stage[0][i*W +: W] <= cell_h_prev[g][i*W +: W] + cell_x[g][W-1:0];
      end
      for (int k = 1; k < CL - 1; k++) begin
        stage[k] <= stage[k-1];
      end
    end
    assign cell_h[g] = stage[CL-2];
  end

  task automatic chk(input int d, input string name, input logic [HB-1:0] act,
                     input logic [HB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL dut%0d %s: got %h expected %h", d, name, act, exp);
    end
  endtask

  task automatic chk1(input int d, input string name, input logic act, input logic exp);
    chk(d, name, HB'(act), HB'(exp));
  endtask

  function automatic vec_t mk(int d, int x0, bit f, int st, int p, bit e, int h, bit l);
    vec_t r;
    r.d = d; r.x0 = W'(x0); r.first = f; r.step = 2'(st); r.prev = W'(p);
    r.emit = e; r.h = W'(h); r.last = l;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input vec_t r, output logic [XB-1:0] xv);
    int n = 0;
    while (!x_ready[r.d] && n < 50) begin
      tick();
      n++;
    end
    chk1(r.d, "x_ready_wait", x_ready[r.d], 1'b1);
    for (int i = 0; i < XS; i++) begin
      xv[i*W +: W] = r.x0 + W'(i * 256);
    end
    x_t[r.d]     = xv;
    x_valid[r.d] = 1'b1;
    x_first[r.d] = r.first;
    tick();
    x_valid[r.d] = 1'b0;
    x_first[r.d] = 1'b0;
  endtask

  // One full step: accept, check cell inputs, check output timing and value.
  task automatic do_step(input vec_t r);
    logic [XB-1:0] xv;
    int d = r.d;
    accept(r, xv);
    chk(d, "cell_x", HB'(cell_x[d]), HB'(xv));
    chk(d, "cell_h_prev", cell_h_prev[d], {HS{r.prev}});
    chk(d, "step_idx", HB'(step_idx[d]), HB'(r.step));
    chk1(d, "x_ready_run", x_ready[d], 1'b0);
    repeat (CL - 1) tick();
    chk1(d, "h_valid_early", h_valid[d], 1'b0);
    tick();
    chk1(d, "h_valid", h_valid[d], r.emit);
    if (r.emit) begin
      chk(d, "h_out", h_out[d], {HS{r.h}});
      chk1(d, "h_last", h_last[d], r.last);
      if (h_ready[d]) begin
        tick();
        chk1(d, "h_valid_drop", h_valid[d], 1'b0);
      end
    end else begin
      chk1(d, "x_ready_idle", x_ready[d], 1'b1);
    end
  endtask

  task automatic chk_zero(input int d);
    chk1(d, "rst_x_ready", x_ready[d], 1'b0);
    chk1(d, "rst_h_valid", h_valid[d], 1'b0);
    chk1(d, "rst_h_last", h_last[d], 1'b0);
    chk(d, "rst_cell_x", HB'(cell_x[d]), '0);
    chk(d, "rst_cell_h_prev", cell_h_prev[d], '0);
    chk(d, "rst_h_out", h_out[d], '0);
    chk(d, "rst_step_idx", HB'(step_idx[d]), '0);
  endtask

  vec_t tbl [15];

  initial begin
    logic [XB-1:0] xv;
    // d, x0, first, step, prev, emit, h, last
    tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 2, 0, 1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 3, 0, 2, 3, 1, 6, 1);
    tbl[3]  = mk(0, 4, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 4, 0, 1, 4, 0, 0, 0);
    tbl[5]  = mk(0, 4, 0, 2, 8, 1, 12, 1);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 2, 0, 1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 5, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 1, 5, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 2, 6, 1, 7, 1);
    tbl[11] = mk(1, 1, 0, 0, 0, 1, 1, 0);
    tbl[12] = mk(1, 2, 0, 1, 1, 1, 3, 0);
    tbl[13] = mk(1, 3, 0, 2, 3, 1, 6, 1);
    tbl[14] = mk(1, 2, 0, 0, 0, 1, 2, 0);

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      x_t[d] = '0; x_valid[d] = 1'b0; x_first[d] = 1'b0; h_ready[d] = 1'b1;
    end
    repeat (2) tick();
    for (int d = 0; d < 2; d++) chk_zero(d);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk1(d, "x_ready_after_reset", x_ready[d], 1'b1);

    for (int i = 0; i < 15; i++) do_step(tbl[i]);

    // Back-pressure on the final-only instance.
    h_ready[0] = 1'b0;
    do_step(mk(0, 1, 0, 0, 0, 0, 0, 0));
    do_step(mk(0, 2, 0, 1, 1, 0, 0, 0));
    do_step(mk(0, 3, 0, 2, 3, 1, 6, 1));
    for (int c = 0; c < 10; c++) begin
      tick();
      chk1(0, "bp_h_valid", h_valid[0], 1'b1);
      chk(0, "bp_h_out", h_out[0], {HS{16'd6}});
      chk1(0, "bp_h_last", h_last[0], 1'b1);
      chk1(0, "bp_x_ready", x_ready[0], 1'b0);
    end
    h_ready[0] = 1'b1;
    tick();
    chk1(0, "bp_release_h_valid", h_valid[0], 1'b0);
    chk(0, "bp_release_step_idx", HB'(step_idx[0]), '0);
    chk1(0, "bp_release_x_ready", x_ready[0], 1'b1);

    // Reset two cycles after the second accept of a sequence.
    do_step(mk(0, 1, 0, 0, 0, 0, 0, 0));
    accept(mk(0, 1, 0, 1, 1, 0, 0, 0), xv);
    chk(0, "mid_cell_h_prev", cell_h_prev[0], {HS{16'd1}});
    tick();
    reset = 1'b1;
    tick();
    chk_zero(0);
    reset = 1'b0;
    do_step(mk(0, 1, 0, 0, 0, 0, 0, 0));
    do_step(mk(0, 1, 0, 1, 1, 0, 0, 0));
    do_step(mk(0, 1, 0, 2, 2, 1, 3, 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
